// File: rtl/ber_align_mod.sv
// PRBS bit-error-rate tester: searches the reference delay that aligns to the
// received stream, locks on a clean window and then counts bits and errors.
module ber_align_mod #(
    parameter int NB_CNT   = 32,
    parameter int MAX_DLY  = 16,
    parameter int NB_DLY   = 4,
    parameter int WIN_LEN  = 64,
    parameter int LOCK_THR = 0,
    parameter int LOSS_THR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_ref_bit,
    input  logic              i_rx_bit,
    input  logic              i_clear,
    output logic              o_locked,
    output logic [NB_DLY-1:0] o_dly,
    output logic [NB_CNT-1:0] o_bit_cnt,
    output logic [NB_CNT-1:0] o_err_cnt,
    output logic              o_sat,
    output logic              o_led
);

    localparam int NB_WIN = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                     state_r, state_nxt_s;
    logic [NB_DLY-1:0]          dly_r, dly_nxt_s, dly_wrap_s;
    logic [NB_WIN-1:0]          win_cnt_r, win_cnt_nxt_s;
    logic [NB_WIN-1:0]          win_err_r, win_err_nxt_s, win_err_inc_s;
    logic                       win_last_s;
    logic [MAX_DLY-2:0]         dline_r;
    logic [MAX_DLY-1:0]         ref_vec_s;
    logic [(1<<NB_DLY)-1:0]     tap_vec_s;
    logic                       tap_s, mismatch_s, count_en_s;
    logic [NB_CNT-1:0]          bit_cnt_r, bit_cnt_nxt_s;
    logic [NB_CNT-1:0]          err_cnt_r, err_cnt_nxt_s;
    logic                       sat_r, sat_nxt_s;
    logic                       locked_r, led_r, led_nxt_s;

    // Saturating increment: sticks at all-ones.
    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    endfunction

    // Compare tap (sampled before the shift) and mismatch detection.
    always_comb begin
        ref_vec_s                = {dline_r, i_ref_bit};
        tap_vec_s                = '0;
        tap_vec_s[MAX_DLY-1:0]   = ref_vec_s;
        tap_s                    = tap_vec_s[dly_r];
        mismatch_s               = i_valid & (i_rx_bit ^ tap_s);
        win_err_inc_s            = win_err_r + {{(NB_WIN-1){1'b0}}, mismatch_s};
        win_last_s               = i_valid && (win_cnt_r == NB_WIN'(WIN_LEN - 1));
        if (dly_r == NB_DLY'(MAX_DLY - 1)) begin
            dly_wrap_s = '0;
        end else begin
            dly_wrap_s = dly_r + {{(NB_DLY-1){1'b0}}, 1'b1};
        end
    end

    // State register together with delay and window counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            dly_r     <= '0;
            win_cnt_r <= '0;
            win_err_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            dly_r     <= dly_nxt_s;
            win_cnt_r <= win_cnt_nxt_s;
            win_err_r <= win_err_nxt_s;
        end
    end

    // Next-state logic: window bookkeeping, lock acquisition and loss.
    always_comb begin
        state_nxt_s   = state_r;
        dly_nxt_s     = dly_r;
        win_cnt_nxt_s = win_cnt_r;
        win_err_nxt_s = win_err_r;
        if (!i_enable) begin
            state_nxt_s   = ST_IDLE;
            dly_nxt_s     = '0;
            win_cnt_nxt_s = '0;
            win_err_nxt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s   = ST_SEARCH;
                    dly_nxt_s     = '0;
                    win_cnt_nxt_s = '0;
                    win_err_nxt_s = '0;
                end
                ST_SEARCH, ST_LOCKED: begin
                    if (win_last_s) begin
                        win_cnt_nxt_s = '0;
                        win_err_nxt_s = '0;
                        if (state_r == ST_SEARCH) begin
                            if (32'(win_err_inc_s) <= LOCK_THR) begin
                                state_nxt_s = ST_LOCKED;
                            end else begin
                                dly_nxt_s = dly_wrap_s;
                            end
                        end else begin
                            if (32'(win_err_inc_s) > LOSS_THR) begin
                                state_nxt_s = ST_SEARCH;
                                dly_nxt_s   = dly_wrap_s;
                            end else begin
                                state_nxt_s = ST_LOCKED;
                            end
                        end
                    end else if (i_valid) begin
                        win_cnt_nxt_s = win_cnt_r + {{(NB_WIN-1){1'b0}}, 1'b1};
                        win_err_nxt_s = win_err_inc_s;
                    end else begin
                        win_cnt_nxt_s = win_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    dly_nxt_s     = '0;
                    win_cnt_nxt_s = '0;
                    win_err_nxt_s = '0;
                end
            endcase
        end
    end

    // Output logic: lock-time counters, sticky saturation and LED.
    always_comb begin
        bit_cnt_nxt_s = bit_cnt_r;
        err_cnt_nxt_s = err_cnt_r;
        sat_nxt_s     = sat_r;
        count_en_s    = i_enable && i_valid && (state_r == ST_LOCKED);
        if (i_clear) begin
            bit_cnt_nxt_s = '0;
            err_cnt_nxt_s = '0;
            sat_nxt_s     = 1'b0;
        end else if (count_en_s) begin
            bit_cnt_nxt_s = sat_inc(bit_cnt_r);
            if (mismatch_s) begin
                err_cnt_nxt_s = sat_inc(err_cnt_r);
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
            sat_nxt_s = sat_r | (&bit_cnt_nxt_s) | (&err_cnt_nxt_s);
        end else begin
            sat_nxt_s = sat_r;
        end
        led_nxt_s = (state_nxt_s == ST_LOCKED) && (err_cnt_nxt_s == '0);
    end

    // Reference delay line; shifts on every strobe regardless of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dline_r <= '0;
        end else if (i_valid) begin
            dline_r <= ref_vec_s[MAX_DLY-2:0];
        end else begin
            dline_r <= dline_r;
        end
    end

    // Registered counters and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
            sat_r     <= 1'b0;
            locked_r  <= 1'b0;
            led_r     <= 1'b0;
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            sat_r     <= sat_nxt_s;
            locked_r  <= (state_nxt_s == ST_LOCKED);
            led_r     <= led_nxt_s;
        end
    end

    assign o_locked  = locked_r;
    assign o_dly     = dly_r;
    assign o_bit_cnt = bit_cnt_r;
    assign o_err_cnt = err_cnt_r;
    assign o_sat     = sat_r;
    assign o_led     = led_r;

endmodule

// File: tb/tb_ber_align_mod.sv
// Directed bench for ber_align_mod: PRBS9 reference, receiver delayed 5 strobes,
// one strobe every 4 cycles; a narrow-counter instance shares the stimulus.
module tb_ber_align_mod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ref_bit = 1'b0;
    logic        i_rx_bit = 1'b0;
    logic        i_clear = 1'b0;

    logic        o_locked, o_sat, o_led;
    logic [3:0]  o_dly;
    logic [31:0] o_bit_cnt, o_err_cnt;
    logic        n_locked, n_sat, n_led;
    logic [3:0]  n_dly;
    logic [3:0]  n_bit_cnt, n_err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  lfsr = 9'h1FF;
    logic [4:0]  hist = 5'b0;

    ber_align_mod dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .i_clear(i_clear),
        .o_locked(o_locked), .o_dly(o_dly), .o_bit_cnt(o_bit_cnt),
        .o_err_cnt(o_err_cnt), .o_sat(o_sat), .o_led(o_led)
    );

    ber_align_mod #(.NB_CNT(4)) dut4 (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .i_clear(i_clear),
        .o_locked(n_locked), .o_dly(n_dly), .o_bit_cnt(n_bit_cnt),
        .o_err_cnt(n_err_cnt), .o_sat(n_sat), .o_led(n_led)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe, entered and left on a falling edge, 4 cycles long.
    task automatic strobe(input bit flip, input bit clr);
        logic r;
        r          = lfsr[8];
        i_valid    = 1'b1;
        i_ref_bit  = r;
        i_rx_bit   = hist[4] ^ flip;
        i_clear    = clr;
        lfsr       = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        hist       = {hist[3:0], r};
        @(negedge clk);
        i_valid    = 1'b0;
        i_clear    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit flip);
        for (int i = 0; i < n; i++) strobe(flip, 1'b0);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_dly", 32'(o_dly), 32'd0);
        chk("rst_bit", o_bit_cnt, 32'd0);
        chk("rst_led", 32'(o_led), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_dly", 32'(o_dly), 32'd0);
        chk("idle_locked", 32'(o_locked), 32'd0);

        // Initial search: delays 0..4 fail, lock on delay 5 after strobe 384
        i_enable = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 5; w++) begin
            run(64, 1'b0);
            chk("search_dly", 32'(o_dly), 32'(w + 1));
            chk("search_unlocked", 32'(o_locked), 32'd0);
        end
        run(63, 1'b0);
        chk("prelock_locked", 32'(o_locked), 32'd0);
        run(1, 1'b0);
        chk("lock_locked", 32'(o_locked), 32'd1);
        chk("lock_dly", 32'(o_dly), 32'd5);
        chk("lock_bit", o_bit_cnt, 32'd0);
        chk("lock_led", 32'(o_led), 32'd1);

        // Clean locked window; narrow instance saturates at strobe 15
        run(14, 1'b0);
        chk("n_bit14", 32'(n_bit_cnt), 32'd14);
        chk("n_sat14", 32'(n_sat), 32'd0);
        run(1, 1'b0);
        chk("n_bit15", 32'(n_bit_cnt), 32'd15);
        chk("n_sat15", 32'(n_sat), 32'd1);
        run(5, 1'b0);
        chk("n_bit20", 32'(n_bit_cnt), 32'd15);
        chk("n_sat20", 32'(n_sat), 32'd1);
        chk("bit20", o_bit_cnt, 32'd20);
        chk("sat20", 32'(o_sat), 32'd0);
        run(44, 1'b0);
        chk("clean_bit", o_bit_cnt, 32'd64);
        chk("clean_err", o_err_cnt, 32'd0);
        chk("clean_led", 32'(o_led), 32'd1);

        // One error per 16 strobes: lock held
        for (int i = 0; i < 64; i++) begin
            strobe((i % 16) == 0, 1'b0);
            if ((i % 16) == 0) chk("inj_err", o_err_cnt, 32'(1 + i / 16));
            if (i == 0) chk("inj_led", 32'(o_led), 32'd0);
        end
        chk("inj_bit", o_bit_cnt, 32'd128);
        chk("inj_locked", 32'(o_locked), 32'd1);
        chk("inj_dly", 32'(o_dly), 32'd5);

        // Inverted receiver for a whole window: lock lost at window end
        run(63, 1'b1);
        chk("inv_locked_mid", 32'(o_locked), 32'd1);
        chk("inv_err_mid", o_err_cnt, 32'd67);
        run(1, 1'b1);
        chk("loss_locked", 32'(o_locked), 32'd0);
        chk("loss_dly", 32'(o_dly), 32'd6);
        chk("loss_bit", o_bit_cnt, 32'd192);
        chk("loss_err", o_err_cnt, 32'd68);

        // Re-search 6..15, wrap, 0..4, relock at 5 with counts held
        for (int w = 0; w < 15; w++) begin
            run(64, 1'b0);
            chk("research_dly", 32'(o_dly), 32'((7 + w) % 16));
            chk("research_unlocked", 32'(o_locked), 32'd0);
        end
        run(64, 1'b0);
        chk("relock_locked", 32'(o_locked), 32'd1);
        chk("relock_dly", 32'(o_dly), 32'd5);
        chk("relock_bit", o_bit_cnt, 32'd192);
        chk("relock_err", o_err_cnt, 32'd68);

        // Clear coinciding with an errored strobe
        strobe(1'b1, 1'b1);
        chk("clr_bit", o_bit_cnt, 32'd0);
        chk("clr_err", o_err_cnt, 32'd0);
        chk("clr_sat", 32'(o_sat), 32'd0);
        chk("clr_locked", 32'(o_locked), 32'd1);
        chk("n_clr_sat", 32'(n_sat), 32'd0);
        strobe(1'b0, 1'b0);
        chk("postclr_bit", o_bit_cnt, 32'd1);
        chk("postclr_led", 32'(o_led), 32'd1);

        // Enable drop: IDLE next cycle, counters held
        i_enable = 1'b0;
        @(negedge clk);
        chk("dis_locked", 32'(o_locked), 32'd0);
        chk("dis_dly", 32'(o_dly), 32'd0);
        chk("dis_bit", o_bit_cnt, 32'd1);
        i_enable = 1'b1;
        @(negedge clk);
        run(10, 1'b0);
        chk("reen_dly", 32'(o_dly), 32'd0);
        chk("reen_bit", o_bit_cnt, 32'd1);

        // Asynchronous reset mid-window, between clock edges
        #3 rst = 1'b0;
        #1;
        chk("arst_bit", o_bit_cnt, 32'd0);
        chk("arst_locked", 32'(o_locked), 32'd0);
        chk("arst_dly", 32'(o_dly), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_dly", 32'(o_dly), 32'd0);
        chk("rel_locked", 32'(o_locked), 32'd0);
        run(64, 1'b0);
        chk("rel_w1_dly", 32'(o_dly), 32'd1);
        chk("rel_w1_locked", 32'(o_locked), 32'd0);
        run(320, 1'b0);
        chk("rel_lock_locked", 32'(o_locked), 32'd1);
        chk("rel_lock_dly", 32'(o_dly), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
